// File: rtl/iq_wakeup_select_if.sv
// Enqueue, CDB broadcast, issue handshake and occupancy signals of the issue-queue scheduler.
// The slave modport is the scheduler side. The master modport is the decode/execute side.
interface iq_wakeup_select_if #(
  parameter int ENTRIES   = 8,
  parameter int TAG_W     = 4,
  parameter int PAYLOAD_W = 32
);
  localparam int CNT_W = $clog2(ENTRIES) + 1;

  logic                 flush;
  logic                 enq_valid;
  logic                 enq_ready;
  logic [TAG_W-1:0]     enq_src1_tag;
  logic                 enq_src1_rdy;
  logic [TAG_W-1:0]     enq_src2_tag;
  logic                 enq_src2_rdy;
  logic [TAG_W-1:0]     enq_dst_tag;
  logic [PAYLOAD_W-1:0] enq_payload;
  logic                 cdb_valid;
  logic [TAG_W-1:0]     cdb_tag;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [TAG_W-1:0]     issue_dst_tag;
  logic [PAYLOAD_W-1:0] issue_payload;
  logic [CNT_W-1:0]     count;

  modport master (
    output flush, enq_valid, enq_src1_tag, enq_src1_rdy, enq_src2_tag, enq_src2_rdy,
           enq_dst_tag, enq_payload, cdb_valid, cdb_tag, issue_ready,
    input  enq_ready, issue_valid, issue_dst_tag, issue_payload, count
  );

  modport slave (
    input  flush, enq_valid, enq_src1_tag, enq_src1_rdy, enq_src2_tag, enq_src2_rdy,
           enq_dst_tag, enq_payload, cdb_valid, cdb_tag, issue_ready,
    output enq_ready, issue_valid, issue_dst_tag, issue_payload, count
  );
endinterface

// File: rtl/iq_wakeup_select.sv
// Issue queue with CDB tag wakeup, same-cycle enqueue bypass and round-robin select.
// The file holds the cmp4 tag comparator and the iq_wakeup_select top module.

module cmp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       eq
);
  assign eq = (a == b);
endmodule

module iq_wakeup_select #(
  parameter int ENTRIES   = 8,
  parameter int TAG_W     = 4,
  parameter int PAYLOAD_W = 32
) (
  input  logic                clk,
  input  logic                rst_aL,
  iq_wakeup_select_if.slave   bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES) + 1;

  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic                 valid;
    logic                 src1_rdy;
    logic                 src2_rdy;
    logic [TAG_W-1:0]     src1_tag;
    logic [TAG_W-1:0]     src2_tag;
    logic [TAG_W-1:0]     dst_tag;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t           q [ENTRIES];
  idx_t             rr_ptr;
  logic [CNT_W-1:0] cnt;

  logic [ENTRIES-1:0] hit1;
  logic [ENTRIES-1:0] hit2;
  logic [ENTRIES-1:0] ready;
  logic               byp1;
  logic               byp2;

  idx_t free_idx;
  idx_t sel_idx;
  idx_t cand;
  logic sel_found;
  logic enq_fire;
  logic issue_fire;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    cmp4 u_cmp_src1 (.a(q[g].src1_tag), .b(bus.cdb_tag), .eq(hit1[g]));
    cmp4 u_cmp_src2 (.a(q[g].src2_tag), .b(bus.cdb_tag), .eq(hit2[g]));
    assign ready[g] = q[g].valid & q[g].src1_rdy & q[g].src2_rdy;
  end

  // An operand produced in the very cycle its consumer enqueues would otherwise be missed.
  cmp4 u_byp_src1 (.a(bus.enq_src1_tag), .b(bus.cdb_tag), .eq(byp1));
  cmp4 u_byp_src2 (.a(bus.enq_src2_tag), .b(bus.cdb_tag), .eq(byp2));

  // NOTE: every variable in a combinational block gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!q[i].valid) free_idx = idx_t'(i);
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_ptr;
    cand      = rr_ptr;
    for (int k = 0; k < ENTRIES; k++) begin
      cand = rr_ptr + idx_t'(k);
      if (!sel_found && ready[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign bus.enq_ready     = rst_aL & ~bus.flush & (cnt < CNT_W'(ENTRIES));
  assign bus.issue_valid   = rst_aL & sel_found;
  assign bus.issue_dst_tag = q[sel_idx].dst_tag;
  assign bus.issue_payload = q[sel_idx].payload;
  assign bus.count         = cnt;

  assign enq_fire   = bus.enq_valid & bus.enq_ready;
  assign issue_fire = bus.issue_valid & bus.issue_ready;

  // NOTE: only the valid bits, pointer and count are reset; tags and payload of
  // an invalid slot are never observed, so the storage array carries no reset.
  always_ff @(posedge clk) begin
    if (!rst_aL || bus.flush) begin
      for (int i = 0; i < ENTRIES; i++) q[i].valid <= 1'b0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (bus.cdb_valid && hit1[i]) q[i].src1_rdy <= 1'b1;
        if (bus.cdb_valid && hit2[i]) q[i].src2_rdy <= 1'b1;
      end

      if (issue_fire) begin
        q[sel_idx].valid <= 1'b0;
        rr_ptr           <= sel_idx + idx_t'(1);
      end

      // The written slot is invalid, so it never collides with the granted one.
      if (enq_fire) begin
        q[free_idx] <= entry_t'{
          valid:    1'b1,
          src1_rdy: bus.enq_src1_rdy | (bus.cdb_valid & byp1),
          src2_rdy: bus.enq_src2_rdy | (bus.cdb_valid & byp2),
          src1_tag: bus.enq_src1_tag,
          src2_tag: bus.enq_src2_tag,
          dst_tag:  bus.enq_dst_tag,
          payload:  bus.enq_payload
        };
      end

      case ({enq_fire, issue_fire})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_iq_wakeup_select.sv
// Self-checking bench for iq_wakeup_select: directed scenarios followed by
// randomized traffic compared against a slot-level reference model.
module tb_iq_wakeup_select;
  localparam int ENTRIES   = 8;
  localparam int TAG_W     = 4;
  localparam int PAYLOAD_W = 32;

  logic clk = 1'b0;
  logic rst_aL;
  int   n_tests = 0;
  int   n_fail  = 0;

  iq_wakeup_select_if #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

  iq_wakeup_select #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .rst_aL(rst_aL), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: one record per slot plus the round-robin start position.
  bit          mv [ENTRIES];
  bit          m1 [ENTRIES];
  bit          m2 [ENTRIES];
  logic [3:0]  mt1 [ENTRIES];
  logic [3:0]  mt2 [ENTRIES];
  logic [3:0]  md [ENTRIES];
  logic [31:0] mp [ENTRIES];
  int          mptr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush        = 1'b0;
    bus.enq_valid    = 1'b0;
    bus.enq_src1_tag = '0;
    bus.enq_src1_rdy = 1'b0;
    bus.enq_src2_tag = '0;
    bus.enq_src2_rdy = 1'b0;
    bus.enq_dst_tag  = '0;
    bus.enq_payload  = '0;
    bus.cdb_valid    = 1'b0;
    bus.cdb_tag      = '0;
    bus.issue_ready  = 1'b0;
  endtask

  task automatic set_enq(input logic r1, input logic [3:0] t1, input logic r2,
                         input logic [3:0] t2, input logic [3:0] d, input logic [31:0] p);
    bus.enq_valid    = 1'b1;
    bus.enq_src1_rdy = r1;
    bus.enq_src1_tag = t1;
    bus.enq_src2_rdy = r2;
    bus.enq_src2_tag = t2;
    bus.enq_dst_tag  = d;
    bus.enq_payload  = p;
  endtask

  // Flush to a clean state (pointer 0), then enqueue n ready entries: dst=i, payload=A000_0000+i.
  task automatic fill_ready(input int n);
    idle();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < n; i++) begin
      set_enq(1'b1, 4'd0, 1'b1, 4'd0, 4'(i), 32'hA000_0000 + 32'(i));
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_aL = 1'b0;
    bus.enq_valid   = 1'b1;
    bus.issue_ready = 1'b1;
    tick(); tick(); #1;
    n_tests++; if (bus.enq_ready !== 1'b0) begin n_fail++; $display("FAIL reset_enq_ready: got %b exp 0", bus.enq_ready); end
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid: got %b exp 0", bus.issue_valid); end
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", bus.count); end
    rst_aL = 1'b1;
    bus.enq_valid = 1'b0;
    #1;
    n_tests++; if (bus.enq_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_enq_ready: got %b exp 1", bus.enq_ready); end
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_issue_valid: got %b exp 0", bus.issue_valid); end
    tick();
  endtask

  task automatic test_basic_issue();
    idle();
    set_enq(1'b1, 4'd0, 1'b1, 4'd0, 4'd3, 32'h1234_5678);
    bus.issue_ready = 1'b1;
    #1;
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty_valid: got %b exp 0", bus.issue_valid); end
    tick();
    bus.enq_valid = 1'b0;
    #1;
    n_tests++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL basic_issue_valid: got %b exp 1", bus.issue_valid); end
    n_tests++; if (bus.issue_dst_tag !== 4'd3) begin n_fail++; $display("FAIL basic_dst: got %0d exp 3", bus.issue_dst_tag); end
    n_tests++; if (bus.issue_payload !== 32'h1234_5678) begin n_fail++; $display("FAIL basic_payload: got %h exp 12345678", bus.issue_payload); end
    n_tests++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL basic_count1: got %0d exp 1", bus.count); end
    tick(); #1;
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL basic_count0: got %0d exp 0", bus.count); end
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %b exp 0", bus.issue_valid); end
  endtask

  task automatic test_wakeup();
    idle();
    bus.issue_ready = 1'b1;
    set_enq(1'b0, 4'd5, 1'b1, 4'd0, 4'd6, 32'h0000_B0B0);
    tick();
    bus.enq_valid = 1'b0;
    #1;
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL wake_waiting: got %b exp 0", bus.issue_valid); end
    tick();
    bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd4;
    #1;
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL wake_bcast4_cycle: got %b exp 0", bus.issue_valid); end
    tick();
    bus.cdb_valid = 1'b0;
    #1;
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL wake_wrong_tag: got %b exp 0", bus.issue_valid); end
    bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd5;
    #1;
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL wake_same_cycle: got %b exp 0", bus.issue_valid); end
    tick();
    bus.cdb_valid = 1'b0;
    #1;
    n_tests++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL wake_issue_valid: got %b exp 1", bus.issue_valid); end
    n_tests++; if (bus.issue_dst_tag !== 4'd6) begin n_fail++; $display("FAIL wake_dst: got %0d exp 6", bus.issue_dst_tag); end
    tick(); #1;
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL wake_count: got %0d exp 0", bus.count); end
    // Both sources waiting on the same producer wake together.
    set_enq(1'b0, 4'd7, 1'b0, 4'd7, 4'd8, 32'h0000_0808);
    tick();
    bus.enq_valid = 1'b0;
    bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd7;
    #1;
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL wake2_before: got %b exp 0", bus.issue_valid); end
    tick();
    bus.cdb_valid = 1'b0;
    #1;
    n_tests++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL wake2_valid: got %b exp 1", bus.issue_valid); end
    n_tests++; if (bus.issue_dst_tag !== 4'd8) begin n_fail++; $display("FAIL wake2_dst: got %0d exp 8", bus.issue_dst_tag); end
    tick();
    idle();
  endtask

  task automatic test_bypass();
    idle();
    bus.issue_ready = 1'b1;
    set_enq(1'b0, 4'd9, 1'b1, 4'd0, 4'd2, 32'h0000_0999);
    bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd9;
    tick();
    bus.enq_valid = 1'b0; bus.cdb_valid = 1'b0;
    #1;
    n_tests++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_valid: got %b exp 1", bus.issue_valid); end
    n_tests++; if (bus.issue_dst_tag !== 4'd2) begin n_fail++; $display("FAIL bypass_dst: got %0d exp 2", bus.issue_dst_tag); end
    tick(); #1;
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL bypass_count: got %0d exp 0", bus.count); end
    idle();
  endtask

  task automatic test_fill_drain();
    fill_ready(ENTRIES);
    #1;
    n_tests++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d exp 8", bus.count); end
    n_tests++; if (bus.enq_ready !== 1'b0) begin n_fail++; $display("FAIL full_enq_ready: got %b exp 0", bus.enq_ready); end
    set_enq(1'b1, 4'd0, 1'b1, 4'd0, 4'd15, 32'hDEAD_BEEF);
    bus.issue_ready = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      #1;
      if (i == 0) begin
        n_tests++; if (bus.enq_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_reuse: got %b exp 0", bus.enq_ready); end
      end
      n_tests++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b exp 1", i, bus.issue_valid); end
      n_tests++; if (bus.issue_dst_tag !== 4'(i)) begin n_fail++; $display("FAIL drain_dst[%0d]: got %0d exp %0d", i, bus.issue_dst_tag, i); end
      n_tests++; if (bus.issue_payload !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("FAIL drain_payload[%0d]: got %h", i, bus.issue_payload); end
      tick();
      bus.enq_valid = 1'b0;
    end
    #1;
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL drain_count: got %0d exp 0", bus.count); end
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b exp 0", bus.issue_valid); end
    // Pointer wrapped to 0: with slots 0 and 1 ready, slot 0 wins.
    bus.issue_ready = 1'b0;
    set_enq(1'b1, 4'd0, 1'b1, 4'd0, 4'd10, 32'h0000_0010);
    tick();
    set_enq(1'b1, 4'd0, 1'b1, 4'd0, 4'd11, 32'h0000_0011);
    tick();
    bus.enq_valid = 1'b0;
    #1;
    n_tests++; if (bus.issue_dst_tag !== 4'd10) begin n_fail++; $display("FAIL wrap_ptr: got %0d exp 10", bus.issue_dst_tag); end
    bus.issue_ready = 1'b1;
    tick(); tick();
    idle();
  endtask

  task automatic test_rr_order();
    int order [4];
    order = '{1, 2, 5, 6};
    idle();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 1 || i == 2 || i == 5 || i == 6) set_enq(1'b1, 4'd0, 1'b1, 4'd0, 4'(i), 32'hC000_0000 + 32'(i));
      else set_enq(1'b0, 4'd12, 1'b1, 4'd0, 4'd14, 32'hFFFF_0000);
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      bus.issue_ready = 1'b0;
      #1;
      n_tests++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b exp 1", k, bus.issue_valid); end
      n_tests++; if (bus.issue_dst_tag !== 4'(order[k])) begin n_fail++; $display("FAIL rr_dst_stall[%0d]: got %0d exp %0d", k, bus.issue_dst_tag, order[k]); end
      n_tests++; if (bus.issue_payload !== 32'hC000_0000 + 32'(order[k])) begin n_fail++; $display("FAIL rr_payload_stall[%0d]: got %h", k, bus.issue_payload); end
      tick();
      bus.issue_ready = 1'b1;
      #1;
      n_tests++; if (bus.issue_dst_tag !== 4'(order[k])) begin n_fail++; $display("FAIL rr_dst_grant[%0d]: got %0d exp %0d", k, bus.issue_dst_tag, order[k]); end
      n_tests++; if (bus.issue_payload !== 32'hC000_0000 + 32'(order[k])) begin n_fail++; $display("FAIL rr_payload_grant[%0d]: got %h", k, bus.issue_payload); end
      tick();
    end
    idle();
    #1;
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL rr_done: got %b exp 0", bus.issue_valid); end
    n_tests++; if (bus.count !== 4'd3) begin n_fail++; $display("FAIL rr_count: got %0d exp 3", bus.count); end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic test_flush_full();
    fill_ready(ENTRIES);
    set_enq(1'b1, 4'd0, 1'b1, 4'd0, 4'd15, 32'hDEAD_BEEF);
    bus.flush = 1'b1;
    #1;
    n_tests++; if (bus.enq_ready !== 1'b0) begin n_fail++; $display("FAIL flush_enq_ready: got %b exp 0", bus.enq_ready); end
    n_tests++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL flush_cycle_valid: got %b exp 1", bus.issue_valid); end
    tick();
    idle();
    #1;
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d exp 0", bus.count); end
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_issue_valid: got %b exp 0", bus.issue_valid); end
    n_tests++; if (bus.enq_ready !== 1'b1) begin n_fail++; $display("FAIL flush_enq_ready_after: got %b exp 1", bus.enq_ready); end
    bus.issue_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped[%0d]: got %b exp 0", c, bus.issue_valid); end
    end
    idle();
  endtask

  task automatic test_reset_midop();
    fill_ready(ENTRIES);
    set_enq(1'b1, 4'd0, 1'b1, 4'd0, 4'd15, 32'hDEAD_BEEF);
    bus.issue_ready = 1'b1;
    rst_aL = 1'b0;
    #1;
    n_tests++; if (bus.enq_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_enq_ready: got %b exp 0", bus.enq_ready); end
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_issue_valid: got %b exp 0", bus.issue_valid); end
    tick();
    rst_aL = 1'b1;
    idle();
    #1;
    n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d exp 0", bus.count); end
    n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after_valid: got %b exp 0", bus.issue_valid); end
    n_tests++; if (bus.enq_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_after_ready: got %b exp 1", bus.enq_ready); end
    bus.issue_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dropped[%0d]: got %b exp 0", c, bus.issue_valid); end
    end
    idle();
  endtask

  task automatic test_random();
    int nvalid, sel, free;
    bit exp_enq_ready;
    idle();
    bus.flush = 1'b1;
    tick();
    for (int i = 0; i < ENTRIES; i++) mv[i] = 1'b0;
    mptr = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.flush        = ($urandom_range(0, 39) == 0);
      bus.enq_valid    = ($urandom_range(0, 9) < 6);
      bus.enq_src1_rdy = $urandom_range(0, 1);
      bus.enq_src1_tag = 4'($urandom_range(0, 5));
      bus.enq_src2_rdy = $urandom_range(0, 1);
      bus.enq_src2_tag = 4'($urandom_range(0, 5));
      bus.enq_dst_tag  = 4'($urandom_range(0, 15));
      bus.enq_payload  = $urandom;
      bus.cdb_valid    = $urandom_range(0, 1);
      bus.cdb_tag      = 4'($urandom_range(0, 5));
      bus.issue_ready  = ($urandom_range(0, 9) < 5);
      #1;
      nvalid = 0;
      for (int i = 0; i < ENTRIES; i++) nvalid += int'(mv[i]);
      exp_enq_ready = (nvalid < ENTRIES) && !bus.flush;
      sel = -1;
      for (int k = 0; k < ENTRIES; k++) begin
        int j;
        j = (mptr + k) % ENTRIES;
        if (sel < 0 && mv[j] && m1[j] && m2[j]) sel = j;
      end
      n_tests++; if (bus.count !== 4'(nvalid)) begin n_fail++; $display("FAIL rand_count@%0d: got %0d exp %0d", cyc, bus.count, nvalid); end
      n_tests++; if (bus.enq_ready !== exp_enq_ready) begin n_fail++; $display("FAIL rand_enq_ready@%0d: got %b exp %b", cyc, bus.enq_ready, exp_enq_ready); end
      n_tests++; if (bus.issue_valid !== (sel >= 0)) begin n_fail++; $display("FAIL rand_issue_valid@%0d: got %b exp %b", cyc, bus.issue_valid, sel >= 0); end
      if (sel >= 0) begin
        n_tests++; if (bus.issue_dst_tag !== md[sel] || bus.issue_payload !== mp[sel]) begin
          n_fail++; $display("FAIL rand_select@%0d: got %0d/%h exp %0d/%h", cyc, bus.issue_dst_tag, bus.issue_payload, md[sel], mp[sel]);
        end
      end
      if (bus.flush) begin
        for (int i = 0; i < ENTRIES; i++) mv[i] = 1'b0;
        mptr = 0;
      end else begin
        free = -1;
        for (int i = 0; i < ENTRIES; i++) if (free < 0 && !mv[i]) free = i;
        for (int i = 0; i < ENTRIES; i++) begin
          if (mv[i] && bus.cdb_valid && mt1[i] == bus.cdb_tag) m1[i] = 1'b1;
          if (mv[i] && bus.cdb_valid && mt2[i] == bus.cdb_tag) m2[i] = 1'b1;
        end
        if (sel >= 0 && bus.issue_ready) begin
          mv[sel] = 1'b0;
          mptr = (sel + 1) % ENTRIES;
        end
        if (bus.enq_valid && exp_enq_ready) begin
          mv[free]  = 1'b1;
          m1[free]  = bus.enq_src1_rdy || (bus.cdb_valid && bus.enq_src1_tag == bus.cdb_tag);
          m2[free]  = bus.enq_src2_rdy || (bus.cdb_valid && bus.enq_src2_tag == bus.cdb_tag);
          mt1[free] = bus.enq_src1_tag;
          mt2[free] = bus.enq_src2_tag;
          md[free]  = bus.enq_dst_tag;
          mp[free]  = bus.enq_payload;
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rst_aL = 1'b0;
    tick(); tick();
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_bypass();
    test_fill_drain();
    test_rr_order();
    test_flush_full();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
